// File: rtl/isodata_pkg.sv
// Shared ISODATA definitions: FSM state encoding, default geometry and the
// exact squared-distance helper used by the clusterer and its downstream stages.
package isodata_pkg;

    localparam int ISO_Q   = 16;
    localparam int ISO_K   = 10;
    localparam int ISO_HCW = 16;
    localparam int ISO_DW  = 2 * ISO_Q + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        READY = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exact: a (Q+1)-bit difference squared fits 2Q+2 bits; the sum of two fits DW.
    function automatic logic [ISO_DW-1:0] sq_dist(
        input logic [ISO_Q-1:0] x,
        input logic [ISO_Q-1:0] y,
        input logic [ISO_Q-1:0] cx,
        input logic [ISO_Q-1:0] cy
    );
        logic signed [ISO_Q:0]     dx;
        logic signed [ISO_Q:0]     dy;
        logic signed [2*ISO_Q+1:0] sx;
        logic signed [2*ISO_Q+1:0] sy;
        dx = $signed({x[ISO_Q-1], x}) - $signed({cx[ISO_Q-1], cx});
        dy = $signed({y[ISO_Q-1], y}) - $signed({cy[ISO_Q-1], cy});
        sx = $signed({{(ISO_Q+1){dx[ISO_Q]}}, dx}) * $signed({{(ISO_Q+1){dx[ISO_Q]}}, dx});
        sy = $signed({{(ISO_Q+1){dy[ISO_Q]}}, dy}) * $signed({{(ISO_Q+1){dy[ISO_Q]}}, dy});
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/isodata_dist_unit.sv
// Combinational squared Euclidean distance between a point and one centroid.
// Evaluated and consumed within a single SCAN cycle.
module isodata_dist_unit #(
    parameter int Q = 16,
    localparam int DW = 2 * Q + 3
) (
    input  logic [Q-1:0]  x,
    input  logic [Q-1:0]  y,
    input  logic [Q-1:0]  cx,
    input  logic [Q-1:0]  cy,
    output logic [DW-1:0] d
);

    logic signed [Q:0]     dx;
    logic signed [Q:0]     dy;
    logic signed [2*Q+1:0] dxe;
    logic signed [2*Q+1:0] dye;
    logic signed [2*Q+1:0] sx;
    logic signed [2*Q+1:0] sy;

    assign dx  = $signed({x[Q-1], x}) - $signed({cx[Q-1], cx});
    assign dy  = $signed({y[Q-1], y}) - $signed({cy[Q-1], cy});
    assign dxe = {{(Q+1){dx[Q]}}, dx};
    assign dye = {{(Q+1){dy[Q]}}, dy};
    assign sx  = dxe * dxe;
    assign sy  = dye * dye;
    // Squares are non-negative, so zero extension of each term is exact.
    assign d   = {1'b0, sx} + {1'b0, sy};

endmodule

// File: rtl/isodata_label_assign.sv
// Nearest-centroid labeller: captures K centroids, scans one per cycle per point.
// Optional per-label histogram is built when ISODATA_HIST_EN is defined.
module isodata_label_assign
    import isodata_pkg::*;
#(
    parameter int Q = ISO_Q,
    parameter int K = ISO_K,
`ifdef ISODATA_HIST_EN
    parameter int HCW = ISO_HCW,
`endif
    localparam int CW = (K > 1) ? $clog2(K) : 1,
    localparam int DW = 2 * Q + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cent_load,
    input  logic [K-1:0][Q-1:0] cent_x,
    input  logic [K-1:0][Q-1:0] cent_y,
    input  logic                pt_valid,
    output logic                pt_ready,
    input  logic [Q-1:0]        pt_x,
    input  logic [Q-1:0]        pt_y,
    output logic                lbl_valid,
    input  logic                lbl_ready,
    output logic [CW-1:0]       lbl_idx,
    output logic [DW-1:0]       lbl_dist,
    output logic                loaded,
`ifdef ISODATA_HIST_EN
    input  logic                  hist_clr,
    output logic [K-1:0][HCW-1:0] hist_cnt,
`endif
    output state_t              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends combinationally on valid, and payload is stable while valid && !ready.

    state_t               state_q, state_d;
    logic [K-1:0][Q-1:0]  cx_q, cy_q, sh_x, sh_y;
    logic                 pend;
    logic [Q-1:0]         px, py;
    logic [CW-1:0]        j;
    logic [DW-1:0]        d;
    logic                 accept, handoff;

    assign pt_ready  = (state_q == READY);
    assign lbl_valid = (state_q == DONE);
    assign dbg_state = state_q;
    assign accept    = pt_ready && pt_valid;
    assign handoff   = lbl_valid && lbl_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (cent_load) state_d = READY;
            READY: if (pt_valid) state_d = SCAN;
            SCAN:  if (j == CW'(K - 1)) state_d = DONE;
            DONE:  if (lbl_ready) state_d = READY;
            default: state_d = EMPTY;
        endcase
    end

    isodata_dist_unit #(.Q(Q)) u_dist (
        .x  (px),
        .y  (py),
        .cx (cx_q[j]),
        .cy (cy_q[j]),
        .d  (d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q     <= '0;
            cy_q     <= '0;
            sh_x     <= '0;
            sh_y     <= '0;
            pend     <= 1'b0;
            loaded   <= 1'b0;
            px       <= '0;
            py       <= '0;
            j        <= '0;
            lbl_idx  <= '0;
            lbl_dist <= '0;
        end else begin
            if (cent_load) loaded <= 1'b1;
            // Idle states take new centroids at once; busy states park them in the shadow.
            if (cent_load && (state_q == EMPTY || state_q == READY)) begin
                cx_q <= cent_x;
                cy_q <= cent_y;
            end
            if (cent_load && (state_q == SCAN || state_q == DONE)) begin
                sh_x <= cent_x;
                sh_y <= cent_y;
                pend <= 1'b1;
            end
            if (handoff) begin
                pend <= 1'b0;
                if (cent_load) begin
                    cx_q <= cent_x;
                    cy_q <= cent_y;
                end else if (pend) begin
                    cx_q <= sh_x;
                    cy_q <= sh_y;
                end
            end
            if (accept) begin
                px       <= pt_x;
                py       <= pt_y;
                j        <= '0;
                lbl_dist <= '1;
            end
            // Strict less-than keeps the lowest index on ties; j==0 always wins.
            if (state_q == SCAN) begin
                if (j == '0 || d < lbl_dist) begin
                    lbl_dist <= d;
                    lbl_idx  <= j;
                end
                j <= j + 1'b1;
            end
        end
    end

`ifdef ISODATA_HIST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_cnt <= '0;
        end else if (hist_clr) begin
            hist_cnt <= '0;
        end else if (handoff && hist_cnt[lbl_idx] != {HCW{1'b1}}) begin
            hist_cnt[lbl_idx] <= hist_cnt[lbl_idx] + 1'b1;
        end
    end
`endif

endmodule
